// File: rtl/mem_port_arbiter_if.sv
// Bundle of every handshake and bus signal around mem_port_arbiter.
//   I port : i_req/i_addr in, i_gnt/i_done/i_rdata/i_err out
//   D port : d_req/d_we/d_addr/d_wdata/d_be in, d_gnt/d_done/d_rdata/d_err out
//   Bus    : bus_req/bus_we/bus_addr/bus_wdata/bus_be out, bus_ack/bus_rdata in
// Modport master is the arbiter's view; modport slave is the view of the
// surrounding pipeline/memory (or a testbench standing in for them).
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        i_err;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt;
    logic        d_done;
    logic [31:0] d_rdata;
    logic [1:0]  d_err;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        input  i_req, i_addr,
        output i_gnt, i_done, i_rdata, i_err,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_gnt, d_done, d_rdata, d_err,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_rdata
    );

    modport slave (
        output i_req, i_addr,
        input  i_gnt, i_done, i_rdata, i_err,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_gnt, d_done, d_rdata, d_err,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one external memory bus between the fetch (I) and data (D) ports.
// D has priority; after STREAK_MAX back-to-back D grants with I waiting, I
// gets the next grant. One transaction outstanding; each bus cycle is aborted
// with an error after TIMEOUT cycles without bus_ack. Misaligned D accesses
// are rejected without a bus cycle.
// Ports:
//   clk   - clock, all state on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - mem_port_arbiter_if.master (I/D request ports and external bus)
module mem_port_arbiter #(
    parameter int unsigned STREAK_MAX = 4,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned TO_W       = 8
) (
    input logic                clk,
    input logic                rst_n,
    mem_port_arbiter_if.master bus
);

    localparam int unsigned SW = $clog2(STREAK_MAX + 1);
    localparam logic [SW-1:0]   StreakMaxV = SW'(STREAK_MAX);
    localparam logic [TO_W-1:0] TimeoutV   = TO_W'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

    state_e          state_q;
    logic [SW-1:0]   streak_q;
    logic [TO_W-1:0] to_cnt_q;

    logic          grant_d;
    logic          grant_i;
    logic          misaligned;
    logic [SW-1:0] streak_d;

    // Grant decision and streak bookkeeping, only acted on in StIdle.
    always_comb begin
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        misaligned = 1'b0;
        streak_d   = streak_q;

        if (bus.d_req && (!bus.i_req || (streak_q < StreakMaxV))) begin
            grant_d = 1'b1;
        end else if (bus.i_req) begin
            grant_i = 1'b1;
        end

        if ((bus.d_be == 4'b1111) && (bus.d_addr[1:0] != 2'b00)) begin
            misaligned = 1'b1;
        end else if (((bus.d_be == 4'b0011) || (bus.d_be == 4'b1100)) && bus.d_addr[0]) begin
            misaligned = 1'b1;
        end

        // A D grant only counts towards the streak while I is actually waiting.
        if (grant_d) begin
            if (bus.i_req) begin
                streak_d = (streak_q == StreakMaxV) ? streak_q : streak_q + SW'(1);
            end else begin
                streak_d = '0;
            end
        end else if (grant_i) begin
            streak_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            streak_q      <= '0;
            to_cnt_q      <= '0;
            bus.i_gnt     <= 1'b0;
            bus.i_done    <= 1'b0;
            bus.i_rdata   <= '0;
            bus.i_err     <= 1'b0;
            bus.d_gnt     <= 1'b0;
            bus.d_done    <= 1'b0;
            bus.d_rdata   <= '0;
            bus.d_err     <= 2'b00;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            bus.bus_be    <= '0;
        end else begin
            // Grant and done strobes are single-cycle pulses.
            bus.i_gnt  <= 1'b0;
            bus.i_done <= 1'b0;
            bus.d_gnt  <= 1'b0;
            bus.d_done <= 1'b0;

            case (state_q)
                StIdle: begin
                    streak_q <= streak_d;
                    to_cnt_q <= '0;
                    if (grant_d) begin
                        bus.d_gnt <= 1'b1;
                        if (misaligned) begin
                            // Rejected at once: gnt and done together, no bus cycle.
                            bus.d_done  <= 1'b1;
                            bus.d_rdata <= '0;
                            bus.d_err   <= 2'b10;
                        end else begin
                            bus.bus_req   <= 1'b1;
                            bus.bus_we    <= bus.d_we;
                            bus.bus_addr  <= bus.d_addr;
                            bus.bus_wdata <= bus.d_wdata;
                            bus.bus_be    <= bus.d_be;
                            state_q       <= StBusyD;
                        end
                    end else if (grant_i) begin
                        bus.i_gnt     <= 1'b1;
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= 1'b0;
                        bus.bus_addr  <= bus.i_addr;
                        bus.bus_wdata <= '0;
                        bus.bus_be    <= 4'b1111;
                        state_q       <= StBusyI;
                    end
                end

                StBusyI, StBusyD: begin
                    // Ack is checked first so it wins over a coincident timeout.
                    if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        to_cnt_q    <= '0;
                        state_q     <= StIdle;
                        if (state_q == StBusyI) begin
                            bus.i_done  <= 1'b1;
                            bus.i_rdata <= bus.bus_rdata;
                            bus.i_err   <= 1'b0;
                        end else begin
                            bus.d_done  <= 1'b1;
                            bus.d_rdata <= bus.bus_we ? '0 : bus.bus_rdata;
                            bus.d_err   <= 2'b00;
                        end
                    end else if (to_cnt_q == TimeoutV) begin
                        bus.bus_req <= 1'b0;
                        to_cnt_q    <= '0;
                        state_q     <= StIdle;
                        if (state_q == StBusyI) begin
                            bus.i_done  <= 1'b1;
                            bus.i_rdata <= '0;
                            bus.i_err   <= 1'b1;
                        end else begin
                            bus.d_done  <= 1'b1;
                            bus.d_rdata <= '0;
                            bus.d_err   <= 2'b01;
                        end
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
